// File: rtl/op_decode_queue.sv
// ALU opcode queue: opcodes are decoded to a 12-bit one-hot select at enqueue
// and held in a small FIFO alongside an illegal flag; illegal pushes are counted.
module op_decode_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [3:0]               in_op,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [11:0]              out_onehot,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         illegal_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // entry layout: [12] illegal, [11:0] one-hot select
  logic [12:0]       r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [LW-1:0]     r_level;
  logic [CNT_W-1:0]  r_cnt;
  logic [12:0]       w_dec;
  logic              w_push, w_pop;

  always_comb begin
    w_dec = {1'b1, 12'h800};
    case (in_op)
      4'h0: w_dec = {1'b0, 12'h001};
      4'h1: w_dec = {1'b0, 12'h002};
      4'h2: w_dec = {1'b0, 12'h004};
      4'h3: w_dec = {1'b0, 12'h008};
      4'h4: w_dec = {1'b0, 12'h010};
      4'h5: w_dec = {1'b0, 12'h020};
      4'h6: w_dec = {1'b0, 12'h040};
      4'h8: w_dec = {1'b0, 12'h080};
      4'h9: w_dec = {1'b0, 12'h100};
      4'hA: w_dec = {1'b0, 12'h200};
      4'hB: w_dec = {1'b0, 12'h400};
      default: w_dec = {1'b1, 12'h800};
    endcase
  end

  // a full queue refuses the push even when the head is popped that same cycle
  assign in_ready  = (r_level < FULL) && !flush;
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push && w_dec[12] && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  // storage needs no reset: an entry is only visible once level covers it
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_dec;
  end

  assign out_onehot  = out_valid ? r_mem[r_rptr][11:0] : 12'h000;
  assign out_illegal = out_valid ? r_mem[r_rptr][12]   : 1'b0;
  assign level       = r_level;
  assign illegal_cnt = r_cnt;
endmodule
